ham_rx_decoder: RTL and testbench

Clocked receive-side network interface for a core: accepts 11-bit Hamming-protected flits from the router, corrects single-bit errors in the 7-bit codeword, and delivers 8-bit {data, address} bytes to the data bucket through a small FIFO. It is the decoder counterpart of the core's transmit-side encoder, which places data bits at flit positions 6, 8, 9 and 10 and parity bits at flit positions 4, 5 and 7. It keeps a saturating count of corrected flits for link-health monitoring.

---
 rtl/ham_rx_decoder_pkg.sv | 39 +++
 rtl/ham_rx_decoder_if.sv | 26 ++
 rtl/ham_rx_fifo.sv | 57 +++++
 rtl/ham_rx_decoder.sv | 68 ++++++
 tb/tb_ham_rx_decoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ham_rx_decoder_pkg.sv
// Shared Hamming(7,4) definitions for the core's network interface.
// Used by the receive-side decoder and the transmit-side encoder.
//   flit_t      : 11-bit router flit, [10:4] codeword, [3:0] address
//   codeword_t  : 7-bit codeword, bit i is codeword position i+1
//   byte_t      : delivered {data, address} byte
//   hamming74_correct(raw) : corrected codeword plus syndrome {P4,P2,P1}
package ham_rx_decoder_pkg;

  typedef logic [10:0] flit_t;
  typedef logic [6:0]  codeword_t;
  typedef logic [7:0]  byte_t;

  // Codeword positions (1-based) that carry parity.
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;

  typedef struct packed {
    codeword_t  word;
    logic [2:0] syndrome;
  } ham_fix_t;

  // Each parity bit checks every position whose index has that parity's bit
  // set, so the syndrome is directly the 1-based position of a single error.
  function automatic ham_fix_t hamming74_correct(input codeword_t raw);
    ham_fix_t  res;
    codeword_t flip;
    res.syndrome = '0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & P1_POS) != 0) res.syndrome[0] = res.syndrome[0] ^ raw[p-1];
      if ((p & P2_POS) != 0) res.syndrome[1] = res.syndrome[1] ^ raw[p-1];
      if ((p & P4_POS) != 0) res.syndrome[2] = res.syndrome[2] ^ raw[p-1];
    end
    flip = (res.syndrome == 3'd0) ? '0 : codeword_t'(7'd1 << (res.syndrome - 3'd1));
    res.word = raw ^ flip;
    return res;
  endfunction

endpackage

// File: rtl/ham_rx_decoder_if.sv
// Handshake bundle between router, decoder and data bucket.
//   in_valid/in_ready/in_flit              : router -> decoder flit stream
//   out_valid/out_ready/out_data/out_corrected : decoder -> bucket byte stream
// slave is the decoder's view, master is the surrounding environment.
interface ham_rx_decoder_if;
  import ham_rx_decoder_pkg::*;

  logic  in_valid;
  logic  in_ready;
  flit_t in_flit;
  logic  out_valid;
  logic  out_ready;
  byte_t out_data;
  logic  out_corrected;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_data, out_corrected
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_data, out_corrected
  );

endinterface

// File: rtl/ham_rx_fifo.sv
// Synchronous circular-buffer FIFO.
//   clk, rst_n   : clock, async active-low reset (clears all entries)
//   push, wdata  : write request, ignored when full
//   pop          : read request, ignored when empty
//   rdata        : head entry (combinational from storage)
//   full, empty  : occupancy flags derived from the registered count
module ham_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ham_rx_decoder.sv
// Receive-side Hamming(7,4) decoder with output buffering.
//   clk, rst_n : clock, async active-low reset
//   bus        : flit input stream and decoded byte output stream
//   clr_count  : synchronous clear of err_count (wins over increment)
//   err_count  : saturating count of accepted flits with non-zero syndrome
// Double-bit errors alias to a single-bit syndrome; they are miscorrected
// and counted like any other correction.
module ham_rx_decoder
  import ham_rx_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ham_rx_decoder_if.slave  bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  ham_fix_t   fix;
  byte_t      dec_byte;
  logic       corrected;
  logic       push;
  logic       full;
  logic       empty;
  logic [8:0] head;
  logic       unused_parity;

  assign fix       = hamming74_correct(bus.in_flit[10:4]);
  assign corrected = (fix.syndrome != 3'd0);
  assign dec_byte  = {fix.word[6], fix.word[5], fix.word[4], fix.word[2], bus.in_flit[3:0]};
  // Parity positions carry no payload once corrected.
  assign unused_parity = ^{fix.word[3], fix.word[1], fix.word[0]};

  // in_ready follows the registered occupancy only, never out_ready.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  ham_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (bus.out_ready),
    .wdata ({corrected, dec_byte}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid     = !empty;
  assign bus.out_data      = head[7:0];
  assign bus.out_corrected = head[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (push && corrected && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_rx_decoder.sv
// Self-checking bench for ham_rx_decoder: directed vectors, backpressure,
// counter saturation/clear, mid-run reset and a randomized run against a
// nearest-codeword reference model.
module tb_ham_rx_decoder;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  localparam logic [10:0] VF [4] = '{11'h525, 11'h565, 11'h535, 11'h515};
  localparam logic [7:0]  VB [4] = '{8'hA5, 8'hA5, 8'hA5, 8'hB5};
  localparam logic        VC [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam int          VN [4] = '{0, 1, 2, 3};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_count;
  logic [CW-1:0] err_count;

  ham_rx_decoder_if bus();

  ham_rx_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];
  int         exp_cnt = 0;

  // Transmit-side encoder: data at raw2, raw4, raw5, raw6.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] r;
    r[2] = d[0];
    r[4] = d[1];
    r[5] = d[2];
    r[6] = d[3];
    r[0] = r[2] ^ r[4] ^ r[6];
    r[1] = r[2] ^ r[5] ^ r[6];
    r[3] = r[4] ^ r[5] ^ r[6];
    return r;
  endfunction

  function automatic logic [3:0] nib(input logic [6:0] r);
    return {r[6], r[5], r[4], r[2]};
  endfunction

  // The code is perfect: every 7-bit word is a codeword or exactly one flip
  // away from one. Decoding = find that nearest codeword.
  function automatic logic [8:0] model_decode(input logic [10:0] f);
    logic [6:0] raw;
    logic [6:0] c;
    raw = f[10:4];
    if (enc(nib(raw)) == raw) return {1'b0, nib(raw), f[3:0]};
    for (int i = 0; i < 7; i++) begin
      c = raw ^ (7'd1 << i);
      if (enc(nib(c)) == c) return {1'b1, nib(c), f[3:0]};
    end
    return 9'h1FF;
  endfunction

  function automatic logic [10:0] gen_flit();
    logic [6:0] raw;
    int         k;
    raw = enc(4'($urandom));
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) raw[$urandom_range(0, 6)] ^= 1'b1;
    return {raw, 4'($urandom)};
  endfunction

  // One clock: drive at negedge, model the edge, return at next negedge.
  task automatic step(input logic v, input logic [10:0] f, input logic rdy,
                      input logic clr, output logic acc);
    logic       pop;
    logic [8:0] d;
    bus.in_valid  = v;
    bus.in_flit   = f;
    bus.out_ready = rdy;
    clr_count     = clr;
    d   = model_decode(f);
    acc = v && (exp_q.size() < DEPTH);
    pop = rdy && (exp_q.size() > 0);
    @(posedge clk);
    if (pop) exp_q.delete(0);
    if (acc) exp_q.push_back(d);
    if (clr) exp_cnt = 0;
    else if (acc && d[8] && exp_cnt < (2**CW - 1)) exp_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr_count    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.out_corrected !== 1'b0) begin errors++; $display("FAIL reset_out_corrected: got %b expected 0", bus.out_corrected); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err_count: got %h expected 0", err_count); end
  endtask

  task automatic test_vectors();
    logic acc;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, VF[i], 1'b1, 1'b0, acc);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== VB[i]) begin errors++; $display("FAIL vec%0d_data: got %h expected %h", i, bus.out_data, VB[i]); end
      checks++; if (bus.out_corrected !== VC[i]) begin errors++; $display("FAIL vec%0d_corrected: got %b expected %b", i, bus.out_corrected, VC[i]); end
      checks++; if (err_count !== CW'(VN[i])) begin errors++; $display("FAIL vec%0d_count: got %0d expected %0d", i, err_count, VN[i]); end
      step(1'b0, 11'h0, 1'b1, 1'b0, acc);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_drain: got %b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] f [5];
    logic [7:0]  first;
    logic        acc;
    logic        sent5;
    for (int i = 0; i < 5; i++) f[i] = gen_flit();
    first = model_decode(f[0]) & 9'h0FF;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, f[i], 1'b0, 1'b0, acc);
      checks++; if (bus.in_ready !== (i < 3)) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected %b", i, bus.in_ready, (i < 3)); end
      checks++; if (bus.out_data !== first) begin errors++; $display("FAIL bp_stable%0d: got %h expected %h", i, bus.out_data, first); end
    end
    sent5 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (exp_q.size() == 0 && sent5) break;
      checks++; if (bus.out_valid !== 1'b1 || {bus.out_corrected, bus.out_data} !== exp_q[0]) begin
        errors++; $display("FAIL bp_drain%0d: got %b/%h expected 1/%h", c, bus.out_valid, {bus.out_corrected, bus.out_data}, exp_q[0]);
      end
      step(!sent5, f[4], 1'b1, 1'b0, acc);
      if (acc) sent5 = 1'b1;
    end
    checks++; if (!(sent5 && exp_q.size() == 0 && bus.out_valid === 1'b0)) begin
      errors++; $display("FAIL bp_done: got valid=%b sent5=%b left=%0d expected valid=0 sent5=1 left=0", bus.out_valid, sent5, exp_q.size());
    end
    checks++; if (err_count !== CW'(exp_cnt)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_counter();
    logic acc;
    step(1'b0, 11'h0, 1'b1, 1'b1, acc);
    checks++; if (err_count !== '0) begin errors++; $display("FAIL cnt_clear: got %0d expected 0", err_count); end
    for (int i = 0; i < 20; i++) step(1'b1, VF[1], 1'b1, 1'b0, acc);
    checks++; if (err_count !== 4'hF) begin errors++; $display("FAIL cnt_saturate: got %h expected F", err_count); end
    step(1'b1, VF[3], 1'b1, 1'b1, acc);
    checks++; if (err_count !== '0) begin errors++; $display("FAIL cnt_clr_priority: got %0d expected 0", err_count); end
    step(1'b0, 11'h0, 1'b1, 1'b0, acc);
    step(1'b0, 11'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_reset_mid();
    logic acc;
    step(1'b1, VF[1], 1'b0, 1'b0, acc);
    step(1'b1, VF[3], 1'b0, 1'b0, acc);
    checks++; if (bus.out_valid !== 1'b1 || err_count !== CW'(exp_cnt)) begin
      errors++; $display("FAIL mid_prefill: got %b/%0d expected 1/%0d", bus.out_valid, err_count, exp_cnt);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL mid_err_count: got %0d expected 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 11'h0, 1'b1, 1'b0, acc);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic acc;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, gen_flit(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, acc);
      checks++; if (bus.in_ready !== (exp_q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", c, bus.in_ready, (exp_q.size() < DEPTH));
      end
      checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", c, bus.out_valid, (exp_q.size() != 0));
      end
      checks++; if (err_count !== CW'(exp_cnt)) begin
        errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, err_count, exp_cnt);
      end
      if (exp_q.size() != 0) begin
        checks++; if ({bus.out_corrected, bus.out_data} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_head@%0d: got %h expected %h", c, {bus.out_corrected, bus.out_data}, exp_q[0]);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_count     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
